// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC capture controller and its testbench.
package adc_pkg;
  localparam int DECIM_W  = 16;
  localparam int CNT_W    = 16;
  localparam int TSTAMP_W = 32;
  localparam int SAMP_W   = 16;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

  // One captured (time, sig) pair at the default widths.
  typedef struct packed {
    logic [TSTAMP_W-1:0]      tstamp;
    logic signed [SAMP_W-1:0] sig;
  } sample_t;
endpackage

// File: rtl/adc_fifo.sv
// First-word-fall-through capture buffer; the caller qualifies push/pop against full/empty.
module adc_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  // Head is forced to zero when nothing is buffered so stale data never leaks out.
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/adc_capture_ctrl.sv
// Armed/triggered decimating capture of (time, sig) pairs into a FWFT buffer.
module adc_capture_ctrl
  import adc_pkg::*;
#(
  parameter int SIG_BITS  = 16,
  parameter int TIME_BITS = 32,
  parameter int DEPTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TIME_BITS-1:0] time_curr,
  input  logic [SIG_BITS-1:0]  sig,
  input  logic                 arm,
  input  logic                 trig,
  input  logic [DECIM_W-1:0]   decim,
  input  logic [CNT_W-1:0]     num_samp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TIME_BITS-1:0] out_time,
  output logic [SIG_BITS-1:0]  out_sig,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);
  localparam int W = TIME_BITS + SIG_BITS;

  state_t             state, state_nxt;
  logic [DECIM_W-1:0] decim_l, decim_cnt;
  logic [CNT_W-1:0]   num_l, samp_cnt;
  logic               arm_acc, trig_acc, cap_end, samp_evt, drain_end;
  logic               push, pop, full, empty;
  logic [W-1:0]       rdata;

  adc_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ({time_curr, sig}),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign out_time  = rdata[SIG_BITS +: TIME_BITS];
  assign out_sig   = rdata[SIG_BITS-1:0];
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    arm_acc   = 1'b0;
    trig_acc  = 1'b0;
    cap_end   = 1'b0;
    samp_evt  = 1'b0;
    drain_end = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy    = 1'b0;
        arm_acc = arm;
        if (arm) state_nxt = ARMED;
      end
      ARMED: begin
        trig_acc = trig;
        if (trig) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        // The count check precedes sampling, so num_samp=0 leaves after one idle cycle.
        cap_end  = (samp_cnt == num_l);
        samp_evt = !cap_end && (decim_cnt == '0);
        if (cap_end) state_nxt = DRAIN;
      end
      DRAIN: begin
        drain_end = empty;
        if (empty) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A full buffer still takes the sample when the head leaves on the same edge.
  assign push = samp_evt && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decim_l   <= '0;
      num_l     <= '0;
      decim_cnt <= '0;
      samp_cnt  <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= drain_end;
      if (arm_acc) begin
        decim_l  <= decim;
        num_l    <= num_samp;
        overflow <= 1'b0;
      end
      if (trig_acc) begin
        decim_cnt <= '0;
        samp_cnt  <= '0;
      end else if (samp_evt) begin
        decim_cnt <= decim_l;
        samp_cnt  <= samp_cnt + 1'b1;
        if (!push) overflow <= 1'b1;
      end else if (state == CAPTURE && !cap_end) begin
        decim_cnt <= decim_cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Randomized self-checking bench: expected streams come from the arm/trig timing and decimation arithmetic.
module tb_adc_capture_ctrl;
  import adc_pkg::*;

  logic        clk = 0, rst_n = 0;
  logic [31:0] time_curr = 0;
  logic signed [15:0] sig = 0;
  logic        arm = 0, trig = 0, out_ready = 0;
  logic [15:0] decim = 0, num_samp = 0;
  logic        out_valid, busy, done, overflow;
  logic [31:0] out_time;
  logic signed [15:0] out_sig;

  adc_capture_ctrl #(.SIG_BITS(16), .TIME_BITS(32), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .time_curr(time_curr), .sig(sig), .arm(arm), .trig(trig),
    .decim(decim), .num_samp(num_samp), .out_valid(out_valid), .out_ready(out_ready),
    .out_time(out_time), .out_sig(out_sig), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int done_cnt = 0;
  logic done_busy = 0, done_prev_busy = 0, prev_busy = 0;
  sample_t got_q[$], exp_q[$];
  logic signed [15:0] sig_at [int unsigned];

  // Emulated time advances once per cycle; sig is fresh random each cycle.
  initial forever begin
    @(posedge clk); #1;
    time_curr = time_curr + 32'd1;
    sig = 16'($urandom);
  end

  // Monitor: log the inputs seen each cycle, accepted pairs and done pulses.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      sig_at[time_curr] = sig;
      if (out_valid && out_ready) got_q.push_back('{tstamp: out_time, sig: out_sig});
      if (done) begin
        done_cnt++;
        done_busy = busy;
        done_prev_busy = prev_busy;
      end
      prev_busy = busy;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Arm with (d, n), scramble the config inputs, trigger; returns time of first CAPTURE cycle.
  task automatic start_capture(input int d, input int n, output int unsigned t0);
    decim = 16'(d); num_samp = 16'(n); arm = 1;
    tick();
    arm = 0; decim = 16'($urandom); num_samp = 16'($urandom); trig = 1;
    tick();
    trig = 0;
    t0 = time_curr;
  endtask

  task automatic wait_done(input int budget, input bit rnd_ready, output bit ok);
    int start = done_cnt;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      if (done_cnt != start) begin ok = 1; break; end
    end
    if (rnd_ready) out_ready = 1;
  endtask

  // Sample k of a capture is taken in capture cycle k*(d+1).
  task automatic build_exp(input int unsigned t0, input int d, input int n);
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      int unsigned t = t0 + k * (d + 1);
      exp_q.push_back('{tstamp: t, sig: sig_at[t]});
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) tick();
    checks++;
    if ({out_valid, busy, done, overflow} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {out_valid, busy, done, overflow});
    end
    checks++;
    if ({out_time, out_sig} !== 48'h0) begin
      errors++; $display("FAIL reset_data got %h want 0", {out_time, out_sig});
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_basic();
    int unsigned t0; bit ok; int dc;
    got_q.delete(); out_ready = 1; dc = done_cnt;
    start_capture(0, 4, t0);
    wait_done(200, 0, ok);
    repeat (3) tick();
    checks++;
    if (!ok || done_cnt - dc != 1) begin
      errors++; $display("FAIL basic_done got %0d pulses want 1", done_cnt - dc);
    end
    checks++;
    if ({done_prev_busy, done_busy} !== 2'b10) begin
      errors++; $display("FAIL basic_busy_edge got %b want 10", {done_prev_busy, done_busy});
    end
    build_exp(t0, 0, 4);
    checks++;
    if (got_q.size() != 4) begin
      errors++; $display("FAIL basic_count got %0d want 4", got_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_pair[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_decim();
    int unsigned t0; bit ok;
    got_q.delete(); out_ready = 1;
    start_capture(2, 3, t0);
    wait_done(200, 0, ok);
    checks++;
    if (!ok || got_q.size() != 3) begin
      errors++; $display("FAIL decim_count got %0d want 3 (done %0d)", got_q.size(), ok);
    end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].tstamp !== t0 + 3 * i || got_q[i].sig !== sig_at[t0 + 3 * i]) begin
        errors++; $display("FAIL decim_time[%0d] got %0d want %0d", i, got_q[i].tstamp, t0 + 3 * i);
      end
    end
  endtask

  task automatic test_overflow();
    int unsigned t0; bit ok;
    got_q.delete(); out_ready = 0;
    start_capture(0, 20, t0);
    repeat (22) tick();
    checks++;
    if (overflow !== 1 || got_q.size() != 0) begin
      errors++; $display("FAIL ovf_flag got %b pops %0d want 1 pops 0", overflow, got_q.size());
    end
    out_ready = 1;
    wait_done(200, 0, ok);
    build_exp(t0, 0, 16);
    checks++;
    if (!ok || got_q.size() != 16) begin
      errors++; $display("FAIL ovf_count got %0d want 16", got_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL ovf_pair[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    tick();
    checks++;
    if ({busy, overflow} !== 2'b01) begin
      errors++; $display("FAIL ovf_idle got busy/ovf %b want 01", {busy, overflow});
    end
    // Re-arm with num_samp=0: overflow clears and the capture ends with nothing buffered.
    got_q.delete();
    decim = 0; num_samp = 0; arm = 1;
    tick();
    arm = 0;
    checks++;
    if ({busy, overflow} !== 2'b10) begin
      errors++; $display("FAIL ovf_clear got busy/ovf %b want 10", {busy, overflow});
    end
    trig = 1;
    tick();
    trig = 0;
    wait_done(20, 0, ok);
    checks++;
    if (!ok || got_q.size() != 0) begin
      errors++; $display("FAIL zero_samp got %0d pairs done %0d want 0 done 1", got_q.size(), ok);
    end
  endtask

  task automatic test_ignored();
    int unsigned t0; bit ok; int dc;
    got_q.delete(); out_ready = 1;
    trig = 1;
    tick();
    trig = 0;
    tick();
    checks++;
    if (busy !== 0) begin
      errors++; $display("FAIL ign_trig_idle got busy %b want 0", busy);
    end
    decim = 0; num_samp = 3; arm = 1; trig = 1;
    tick();
    arm = 0; trig = 0;
    repeat (5) tick();
    checks++;
    if ({busy, out_valid} !== 2'b10 || got_q.size() != 0) begin
      errors++; $display("FAIL ign_arm_trig got busy/valid %b want 10", {busy, out_valid});
    end
    dc = done_cnt;
    trig = 1;
    tick();
    trig = 0; t0 = time_curr;
    arm = 1; decim = 5; num_samp = 9;
    repeat (2) tick();
    arm = 0;
    wait_done(200, 0, ok);
    build_exp(t0, 0, 3);
    checks++;
    if (!ok || got_q.size() != 3 || done_cnt - dc != 1) begin
      errors++; $display("FAIL ign_arm_capture got %0d pairs want 3", got_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL ign_pair[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int unsigned t0; bit ok; int dc;
    got_q.delete(); out_ready = 0;
    start_capture(0, 10, t0);
    repeat (5) tick();
    checks++;
    if ({busy, out_valid} !== 2'b11) begin
      errors++; $display("FAIL rmid_pre got busy/valid %b want 11", {busy, out_valid});
    end
    dc = done_cnt;
    rst_n = 0;
    #1;
    checks++;
    if ({out_valid, busy, overflow, out_time, out_sig} !== 51'h0) begin
      errors++; $display("FAIL rmid_async got valid %b busy %b data %h want 0", out_valid, busy, {out_time, out_sig});
    end
    tick();
    rst_n = 1;
    repeat (4) tick();
    checks++;
    if (done_cnt != dc || busy !== 0 || out_valid !== 0) begin
      errors++; $display("FAIL rmid_after got done %0d busy %b want 0 0", done_cnt - dc, busy);
    end
    got_q.delete(); out_ready = 1;
    start_capture(1, 4, t0);
    wait_done(200, 0, ok);
    build_exp(t0, 1, 4);
    checks++;
    if (!ok || got_q.size() != 4) begin
      errors++; $display("FAIL rmid_recap got %0d pairs want 4", got_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rmid_pair[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int unsigned t0; bit ok;
    got_q.delete(); out_ready = 0;
    start_capture(0, 17, t0);
    repeat (16) tick();
    checks++;
    if ({out_valid, overflow} !== 2'b10) begin
      errors++; $display("FAIL bp_full got valid/ovf %b want 10", {out_valid, overflow});
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    tick();
    checks++;
    if (overflow !== 0 || got_q.size() != 1) begin
      errors++; $display("FAIL bp_edge got ovf %b pops %0d want 0 1", overflow, got_q.size());
    end
    out_ready = 1;
    wait_done(200, 0, ok);
    build_exp(t0, 0, 17);
    checks++;
    if (!ok || got_q.size() != 17 || overflow !== 0) begin
      errors++; $display("FAIL bp_total got %0d ovf %b want 17 0", got_q.size(), overflow);
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_pair[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int unsigned t0; bit ok; int d, n;
      d = $urandom_range(0, 3);
      n = $urandom_range(1, 12);
      got_q.delete(); out_ready = 1'($urandom_range(0, 1));
      start_capture(d, n, t0);
      wait_done(500, 1, ok);
      build_exp(t0, d, n);
      checks++;
      if (!ok || got_q.size() != n || overflow !== 0) begin
        errors++; $display("FAIL rand%0d_count got %0d ovf %b want %0d 0", it, got_q.size(), overflow, n);
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand%0d_pair[%0d] got %h want %h", it, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decim();
    test_overflow();
    test_ignored();
    test_reset_mid();
    test_backpressure();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_capture_ctrl.md
ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

Interface
REQ-001 Parameter SIG_BITS, default 16, signed sample width.
REQ-002 Parameter TIME_BITS, default 32, timestamp width.
REQ-003 Parameter DEPTH, default 16, capture buffer entries; power of two, at least 2.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 time_curr  in  TIME_BITS  current emulated time.
REQ-007 sig  in  SIG_BITS  signed signal under observation.
REQ-008 arm  in  1  request to arm a capture.
REQ-009 trig  in  1  capture start event.
REQ-010 decim  in  16  sample every decim+1 cycles.
REQ-011 num_samp  in  16  samples per capture.
REQ-012 out_valid  out  1  buffered (time, sig) pair available.
REQ-013 out_ready  in  1  consumer accepts the pair.
REQ-014 out_time  out  TIME_BITS  timestamp of the head entry.
REQ-015 out_sig  out  SIG_BITS  sample value of the head entry.
REQ-016 busy  out  1  high in ARMED, CAPTURE and DRAIN.
REQ-017 done  out  1  one-cycle pulse at the end of a capture.
REQ-018 overflow  out  1  sticky flag: at least one sample was dropped.

Function
REQ-019 The FSM SHALL have four states: IDLE, ARMED, CAPTURE and DRAIN.
- IDLE->ARMED on arm.
- ARMED->CAPTURE on trig.
- CAPTURE->DRAIN when the sample counter reaches num_samp.
- DRAIN->IDLE when the buffer is empty; done pulses on the same edge.
REQ-020 decim and num_samp SHALL be latched on the edge that accepts arm; later changes SHALL have no effect until the next arm.
REQ-021 arm SHALL be ignored outside IDLE, and trig SHALL be ignored outside ARMED.
REQ-022 trig asserted in the same cycle as arm SHALL be ignored.
REQ-023 In CAPTURE, a decimation counter SHALL start at 0 and push {time_curr, sig} on every cycle in which it equals 0.
- After each push the counter SHALL reload to the latched decim and count down.
- decim=0 SHALL sample every cycle.
REQ-024 The first sample SHALL be taken in the first CAPTURE cycle, i.e. the cycle after trig is accepted.
REQ-025 The sample counter SHALL increment on every sample event, including dropped ones.
REQ-026 num_samp=0 SHALL go CAPTURE->DRAIN after one cycle with no sample taken.
REQ-027 The buffer SHALL be first-word-fall-through.
- out_valid SHALL rise the cycle after the first push into an empty buffer.
- A pop SHALL occur when out_valid and out_ready are both high.
REQ-028 When the buffer is full, a push SHALL succeed only if a pop occurs in the same cycle; otherwise the sample SHALL be dropped and overflow set.
REQ-029 overflow SHALL clear only on arm acceptance or reset.
REQ-030 Push and pop in the same cycle on a non-full buffer SHALL leave the occupancy unchanged.
REQ-031 Draining SHALL continue while out_ready is low; DRAIN SHALL wait indefinitely.
REQ-032 Timestamps SHALL pass through unmodified, with no fixed-point rescaling in this block.

Reset
REQ-033 On rst_n low the block SHALL, regardless of state or mid-capture progress:
- enter IDLE;
- empty the buffer;
- clear both counters;
- drive out_valid=0, busy=0, done=0, overflow=0.
REQ-034 out_time and out_sig SHALL be 0 while out_valid=0 after reset.
REQ-035 A capture in progress at reset SHALL be discarded with no done pulse.

Structure
REQ-036 Shared package adc_pkg SHALL hold the state enum, the DECIM_W=16 and CNT_W=16 constants, and the sample struct {time, sig}.
REQ-037 The buffer SHALL be a sub-module adc_fifo, parameterized by width and DEPTH, with full/empty flags; the FSM and counters SHALL stay in adc_capture_ctrl.

Verification
REQ-038 Test 1, basic capture: decim=0, num_samp=4, arm, then trig, with out_ready=1.
- Required: 4 pairs with consecutive time_curr values.
- Required: done pulses once, and busy deasserts on the same edge.
REQ-039 Test 2, decimation: decim=2, num_samp=3, with time_curr incrementing by 1 from T at the first CAPTURE cycle.
- Required: out_time = T, T+3, T+6.
REQ-040 Test 3, overflow: DEPTH=16, num_samp=20, out_ready=0 until DRAIN.
- Required: exactly 16 entries returned, and overflow=1.
- Required: overflow still 1 in IDLE, and cleared by the next arm.
REQ-041 Test 4, ignored controls: pulse trig in IDLE, then arm and trig together.
- Required: state stays ARMED and no samples are taken.
- Required: a later arm during CAPTURE has no effect.
REQ-042 Test 5, reset mid-operation: rst_n low for 1 cycle midway through CAPTURE with 5 entries buffered.
- Required: out_valid=0 immediately, busy=0, no done pulse.
- Required: a new capture then succeeds normally.
REQ-043 Test 6, backpressure corner: full buffer with out_ready=1 on a sample cycle.
- Required: the push is accepted, occupancy stays DEPTH, and there is no overflow.
